param_datapath: RTL and testbench
=================================

Name: param_datapath

Overview:
- Parametrised register-file datapath: 2**REG_AW registers of WIDTH bits, one ALU, and an on-chip sequencer.
- Executes one command per valid/ready handshake.
- Supports INC/ADD/SUB/LOAD/CMP and an iterative multi-cycle left shift by a variable amount.
- Generalises the fixed 3-register 32-bit inc/add/sll datapath. Intended as the core execution unit under a higher-level controller.

Parameters:
WIDTH, 32, register/data width (>=2)
REG_AW, 2, register address width; register count = 2**REG_AW
(localparam SHW = $clog2(WIDTH), shift-amount width)

Ports:
clk  in  1  clock, rising edge
res  in  1  asynchronous reset, active-low
cmd_valid  in  1  command offered
cmd_ready  out  1  datapath can accept a command
cmd_op  in  3  opcode
cmd_dst  in  REG_AW  destination register
cmd_srca  in  REG_AW  operand A register
cmd_srcb  in  REG_AW  operand B register
cmd_imm_sel  in  1  1: operand A' = in; 0: A' = reg[srca]
in  in  WIDTH  immediate data
shamt  in  SHW  shift amount for SLL/SRA
done  out  1  one-cycle pulse: command completed
result  out  WIDTH  value written or computed by last command
carry  out  1  ADD/INC carry-out; SUB borrow
eq  out  1  (A' == B) of last completed command
dbg_sel  in  REG_AW  debug read select
dbg_data  out  WIDTH  combinational reg[dbg_sel]

Behaviour:
- Clock and reset: single clock clk; res is asynchronous, active-low.
- Reset (res=0), asynchronous:
  - all registers 0; state IDLE.
  - result=0, carry=0, eq=0, done=0; cmd_ready=1 once res=1.
- Handshake: accept on a clk edge with cmd_valid & cmd_ready.
  - Latched at the accept edge: op, dst, shamt, A' (in or reg[srca]), B (reg[srcb]).
  - cmd_ready=1 only in IDLE.
- FSM states: IDLE, EXEC, SHIFT.
  - IDLE -> EXEC on accept.
  - EXEC -> SHIFT if op is SLL (or SRA when enabled) and shamt!=0; otherwise -> IDLE with writeback at that edge.
  - SHIFT -> IDLE with writeback when cnt==0.
- Opcodes (writes go to reg[dst]):
  - 000 NOP: no write.
  - 001 INC: B+1.
  - 010 ADD: A'+B.
  - 011 SLL: B<<shamt.
  - 100 SUB: A'-B.
  - 101 LOAD: A'.
  - 110 CMP: no write; result=A'.
  - 111: see Optional Feature.
- Arithmetic: modulo 2**WIDTH.
  - carry = bit WIDTH of the (WIDTH+1)-bit sum for INC/ADD.
  - For SUB, carry=1 iff A'<B (unsigned borrow).
  - All other ops clear carry.
- Iterative shift:
  - EXEC loads acc=B<<1, cnt=shamt-1.
  - Each SHIFT cycle: if cnt!=0, acc<<=1 and cnt-=1; else write acc.
  - One bit per cycle; bits shifted past WIDTH are lost.
- Latency (handshake at edge T0):
  - Writeback edge is T1 for non-shift ops and for shift with shamt=0.
  - Writeback edge is T(1+shamt) for shift with shamt>0.
  - done, result, carry and eq are registered at the writeback edge; done is high exactly one cycle.
  - cmd_ready returns high in the same cycle as done.
  - Max throughput: 1 command per 2 cycles.
- eq is updated on every completed command and held otherwise.
- Hazards: none. The next command is accepted only after writeback, so its operands see the updated register file.
- dbg_data is combinational and reflects the write in the cycle after the writeback edge.
- Reset mid-operation:
  - the command is aborted; no writeback, no done.
  - all registers clear.
- cmd_valid with cmd_ready=0 is ignored; the source holds the command.
- Out-of-range values are impossible: dst, srca and srcb are full REG_AW.

Optional Feature:
- Macro: PARAM_DATAPATH_SRA_EN.
- Defined: opcode 111 = arithmetic shift right, B>>>shamt.
  - Uses the same iterative SHIFT path, replicating the MSB.
  - Same latency as SLL; carry=0.
- Undefined: opcode 111 behaves exactly as NOP: done after T1, no write, eq updated, carry=0.

Test Plan:
- Reset, then LOAD imm_sel=1 in=0x000000FF dst=1 -> done high cycle after T1, result=0x000000FF, dbg_sel=1 reads 0x000000FF, carry=0.
- R1=0xFFFFFFFF, INC srcb=1 dst=2 -> result=0x00000000, carry=1, reg2=0.
- SUB imm_sel=1 in=5, srcb=R1 holding 7 -> result=0xFFFFFFFE, carry=1; then CMP in=0x1234 vs R3=0x1234 -> eq=1, no register change.
- SLL srcb=R1=0x00000001 shamt=4 -> cmd_ready low 5 cycles, writeback at T5, result=0x00000010; repeat with shamt=0 -> writeback at T1, result=0x00000001.
- Back-to-back: LOAD R0=3 then ADD dst=0 srca=0 srcb=0 offered continuously -> second accepted in done cycle, result=6.
- SLL shamt=20 in progress, res low 4 cycles after accept -> no done, all registers 0, cmd_ready=1 after release; with SRA_EN, SRA of 0x80000000 shamt=4 -> 0xF8000000.

Source files
------------

// File: rtl/param_datapath.sv
// param_datapath: register-file datapath with ALU, iterative shifter and command FSM (optional SRA via PARAM_DATAPATH_SRA_EN)
module param_datapath #(
  parameter int WIDTH = 32,
  parameter int REG_AW = 2,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              res,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [REG_AW-1:0] cmd_dst,
  input  logic [REG_AW-1:0] cmd_srca,
  input  logic [REG_AW-1:0] cmd_srcb,
  input  logic              cmd_imm_sel,
  input  logic [WIDTH-1:0]  in,
  input  logic [SHW-1:0]    shamt,
  output logic              done,
  output logic [WIDTH-1:0]  result,
  output logic              carry,
  output logic              eq,
  input  logic [REG_AW-1:0] dbg_sel,
  output logic [WIDTH-1:0]  dbg_data
);
  localparam int NREG = 2 ** REG_AW;
  localparam logic [2:0] OP_INC = 3'd1, OP_ADD = 3'd2, OP_SLL = 3'd3,
                         OP_SUB = 3'd4, OP_LOAD = 3'd5, OP_CMP = 3'd6, OP_SRA = 3'd7;
`ifdef PARAM_DATAPATH_SRA_EN
  localparam bit SRA_EN = 1'b1;
`else
  localparam bit SRA_EN = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, EXEC, SHIFT} state_t;
  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [REG_AW-1:0] dst_q, dst_d;
  logic [SHW-1:0]    shamt_q, shamt_d, cnt_q, cnt_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [WIDTH-1:0]  regs_q [NREG];
  logic [WIDTH-1:0]  regs_d [NREG];
  logic              done_q, done_d, carry_q, carry_d, eq_q, eq_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic [WIDTH:0]    s_inc, s_add;
  logic [WIDTH-1:0]  alu_res, shift_res;
  logic              alu_c, alu_wr, is_sra, is_shift, fin;
  assign cmd_ready = (state_q == IDLE);
  assign done      = done_q;
  assign result    = result_q;
  assign carry     = carry_q;
  assign eq        = eq_q;
  assign dbg_data  = regs_q[dbg_sel];
  assign is_sra    = SRA_EN && (op_q == OP_SRA);
  assign is_shift  = (op_q == OP_SLL) || is_sra;
  // One shift step on a value; arithmetic right replicates the sign bit.
  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] v, input logic sra);
    return sra ? {v[WIDTH-1], v[WIDTH-1:1]} : {v[WIDTH-2:0], 1'b0};
  endfunction
  // ALU result, carry and write enable for the latched command.
  always_comb begin
    s_inc     = {1'b0, b_q} + (WIDTH+1)'(1);
    s_add     = {1'b0, a_q} + {1'b0, b_q};
    shift_res = (state_q == SHIFT) ? acc_q : b_q;
    alu_res   = result_q;
    alu_c     = 1'b0;
    alu_wr    = 1'b0;
    case (op_q)
      OP_INC:  begin alu_res = s_inc[WIDTH-1:0]; alu_c = s_inc[WIDTH]; alu_wr = 1'b1; end
      OP_ADD:  begin alu_res = s_add[WIDTH-1:0]; alu_c = s_add[WIDTH]; alu_wr = 1'b1; end
      OP_SLL:  begin alu_res = shift_res; alu_wr = 1'b1; end
      OP_SUB:  begin alu_res = a_q - b_q; alu_c = (a_q < b_q); alu_wr = 1'b1; end
      OP_LOAD: begin alu_res = a_q; alu_wr = 1'b1; end
      OP_CMP:  alu_res = a_q;
      OP_SRA:  begin alu_res = SRA_EN ? shift_res : result_q; alu_wr = SRA_EN; end
      default: alu_wr = 1'b0;
    endcase
  end
  // Sequencer: accept in IDLE, execute or iterate shifts, write back on completion.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    dst_d    = dst_q;
    shamt_d  = shamt_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    regs_d   = regs_q;
    done_d   = 1'b0;
    result_d = result_q;
    carry_d  = carry_q;
    eq_d     = eq_q;
    fin      = 1'b0;
    case (state_q)
      IDLE: if (cmd_valid) begin
        state_d = EXEC;
        op_d    = cmd_op;
        dst_d   = cmd_dst;
        shamt_d = shamt;
        a_d     = cmd_imm_sel ? in : regs_q[cmd_srca];
        b_d     = regs_q[cmd_srcb];
      end
      EXEC: if (is_shift && shamt_q != '0) begin
        state_d = SHIFT;
        acc_d   = step(b_q, is_sra);
        cnt_d   = shamt_q - SHW'(1);
      end else begin
        state_d = IDLE;
        fin     = 1'b1;
      end
      SHIFT: if (cnt_q != '0) begin
        acc_d = step(acc_q, is_sra);
        cnt_d = cnt_q - SHW'(1);
      end else begin
        state_d = IDLE;
        fin     = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (fin) begin
      done_d   = 1'b1;
      result_d = alu_res;
      carry_d  = alu_c;
      eq_d     = (a_q == b_q);
      if (alu_wr) regs_d[dst_q] = alu_res;
    end
  end
  // State, operand latches, register file and registered outputs.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q  <= IDLE;
      op_q     <= '0;
      dst_q    <= '0;
      shamt_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      eq_q     <= 1'b0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      dst_q    <= dst_d;
      shamt_q  <= shamt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      eq_q     <= eq_d;
      for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
    end
  end
endmodule

// File: tb/tb_param_datapath.sv
// tb_param_datapath: directed self-checking bench for param_datapath
module tb_param_datapath;
  logic        clk = 1'b0;
  logic        res = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = '0;
  logic [1:0]  cmd_dst = '0, cmd_srca = '0, cmd_srcb = '0, dbg_sel = '0;
  logic        cmd_imm_sel = 1'b0;
  logic [31:0] in = '0;
  logic [4:0]  shamt = '0;
  logic        done, carry, eq;
  logic [31:0] result, dbg_data;
  int checks = 0;
  int errors = 0;
  int lat, busy, n, seen;
  param_datapath #(.WIDTH(32), .REG_AW(2)) dut (
    .clk(clk), .res(res), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_srca(cmd_srca), .cmd_srcb(cmd_srcb),
    .cmd_imm_sel(cmd_imm_sel), .in(in), .shamt(shamt), .done(done),
    .result(result), .carry(carry), .eq(eq), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic rd(input logic [1:0] sel, input logic [31:0] exp, input string tag);
    dbg_sel = sel;
    #1;
    chk(tag, dbg_data, exp);
  endtask
  // Issue one command and wait for done; returns cycles to done and cycles with ready low.
  task automatic send(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] sa,
                      input logic [1:0] sb, input logic imm, input logic [31:0] d,
                      input logic [4:0] sh, output int l, output int b);
    int w;
    @(negedge clk);
    cmd_op = op; cmd_dst = dst; cmd_srca = sa; cmd_srcb = sb;
    cmd_imm_sel = imm; in = d; shamt = sh; cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 100) begin @(negedge clk); w++; end
    if (w >= 100) chk("ready_timeout", 32'(w), 32'd0);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    b = cmd_ready ? 0 : 1;
    l = 0;
    while (l < 100) begin
      @(posedge clk);
      l++;
      @(negedge clk);
      if (done) break;
      if (!cmd_ready) b++;
    end
    if (l >= 100) chk("done_timeout", 32'(l), 32'd0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_result", result, 32'h0);
    chk("rst_flags", {29'd0, done, carry, eq}, 32'h0);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    for (int i = 0; i < 4; i++) rd(2'(i), 32'h0, "rst_reg");
    @(negedge clk);
    res = 1'b1;
    send(3'd5, 2'd1, 2'd0, 2'd0, 1'b1, 32'h0000_00FF, 5'd0, lat, busy);
    chk("load_lat", 32'(lat), 32'd1);
    chk("load_res", result, 32'h0000_00FF);
    chk("load_carry", {31'd0, carry}, 32'd0);
    chk("load_ready", {31'd0, cmd_ready}, 32'd1);
    rd(2'd1, 32'h0000_00FF, "load_dbg");
    @(negedge clk);
    chk("done_pulse", {31'd0, done}, 32'd0);
    send(3'd5, 2'd1, 2'd0, 2'd0, 1'b1, 32'hFFFF_FFFF, 5'd0, lat, busy);
    send(3'd1, 2'd2, 2'd0, 2'd1, 1'b0, 32'h0, 5'd0, lat, busy);
    chk("inc_res", result, 32'h0);
    chk("inc_carry", {31'd0, carry}, 32'd1);
    chk("inc_eq", {31'd0, eq}, 32'd0);
    rd(2'd2, 32'h0, "inc_dbg");
    send(3'd2, 2'd3, 2'd0, 2'd1, 1'b1, 32'h2, 5'd0, lat, busy);
    chk("add_res", result, 32'h1);
    chk("add_carry", {31'd0, carry}, 32'd1);
    send(3'd5, 2'd1, 2'd0, 2'd0, 1'b1, 32'h7, 5'd0, lat, busy);
    send(3'd4, 2'd2, 2'd0, 2'd1, 1'b1, 32'h5, 5'd0, lat, busy);
    chk("sub_res", result, 32'hFFFF_FFFE);
    chk("sub_borrow", {31'd0, carry}, 32'd1);
    send(3'd5, 2'd3, 2'd0, 2'd0, 1'b1, 32'h1234, 5'd0, lat, busy);
    chk("load3_carry", {31'd0, carry}, 32'd0);
    send(3'd6, 2'd0, 2'd0, 2'd3, 1'b1, 32'h1234, 5'd0, lat, busy);
    chk("cmp_eq", {31'd0, eq}, 32'd1);
    chk("cmp_res", result, 32'h1234);
    rd(2'd0, 32'h0, "cmp_nowr0");
    rd(2'd2, 32'hFFFF_FFFE, "cmp_nowr2");
    send(3'd5, 2'd1, 2'd0, 2'd0, 1'b1, 32'h1, 5'd0, lat, busy);
    send(3'd3, 2'd2, 2'd0, 2'd1, 1'b0, 32'h0, 5'd4, lat, busy);
    chk("sll4_lat", 32'(lat), 32'd5);
    chk("sll4_busy", 32'(busy), 32'd5);
    chk("sll4_res", result, 32'h10);
    rd(2'd2, 32'h10, "sll4_dbg");
    send(3'd3, 2'd2, 2'd0, 2'd1, 1'b0, 32'h0, 5'd0, lat, busy);
    chk("sll0_lat", 32'(lat), 32'd1);
    chk("sll0_res", result, 32'h1);
    send(3'd5, 2'd1, 2'd0, 2'd0, 1'b1, 32'h4000_0001, 5'd0, lat, busy);
    send(3'd3, 2'd3, 2'd0, 2'd1, 1'b0, 32'h0, 5'd2, lat, busy);
    chk("sll_lost", result, 32'h0000_0004);
`ifdef PARAM_DATAPATH_SRA_EN
    send(3'd5, 2'd1, 2'd0, 2'd0, 1'b1, 32'h8000_0000, 5'd0, lat, busy);
    send(3'd7, 2'd2, 2'd0, 2'd1, 1'b0, 32'h0, 5'd4, lat, busy);
    chk("sra_lat", 32'(lat), 32'd5);
    chk("sra_res", result, 32'hF800_0000);
    chk("sra_carry", {31'd0, carry}, 32'd0);
    rd(2'd2, 32'hF800_0000, "sra_dbg");
`else
    send(3'd5, 2'd2, 2'd0, 2'd0, 1'b1, 32'hAA, 5'd0, lat, busy);
    send(3'd5, 2'd1, 2'd0, 2'd0, 1'b1, 32'hFFFF_FFFF, 5'd0, lat, busy);
    send(3'd1, 2'd3, 2'd0, 2'd1, 1'b0, 32'h0, 5'd0, lat, busy);
    send(3'd7, 2'd2, 2'd0, 2'd2, 1'b1, 32'hAA, 5'd4, lat, busy);
    chk("op7_lat", 32'(lat), 32'd1);
    chk("op7_carry", {31'd0, carry}, 32'd0);
    chk("op7_eq", {31'd0, eq}, 32'd1);
    rd(2'd2, 32'hAA, "op7_nowr");
`endif
    @(negedge clk);
    cmd_op = 3'd5; cmd_dst = 2'd0; cmd_imm_sel = 1'b1; in = 32'h3; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_op = 3'd2; cmd_dst = 2'd0; cmd_srca = 2'd0; cmd_srcb = 2'd0; cmd_imm_sel = 1'b0;
    n = 0;
    while (!done && n < 20) begin @(posedge clk); n++; @(negedge clk); end
    chk("b2b_load", result, 32'h3);
    chk("b2b_ready", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("b2b_accept", {30'd0, cmd_ready, done}, 32'd0);
    n = 0;
    while (!done && n < 20) begin @(posedge clk); n++; @(negedge clk); end
    chk("b2b_lat", 32'(n), 32'd1);
    chk("b2b_add", result, 32'h6);
    chk("b2b_eq", {31'd0, eq}, 32'd1);
    send(3'd5, 2'd1, 2'd0, 2'd0, 1'b1, 32'h0001_0000, 5'd0, lat, busy);
    @(negedge clk);
    cmd_op = 3'd3; cmd_dst = 2'd2; cmd_srcb = 2'd1; cmd_imm_sel = 1'b0; shamt = 5'd20;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    res = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) rd(2'(i), 32'h0, "abort_reg");
    chk("abort_out", {result[30:0], done}, 32'h0);
    repeat (2) @(negedge clk);
    res = 1'b1;
    @(negedge clk);
    chk("abort_ready", {31'd0, cmd_ready}, 32'd1);
    seen = 0;
    repeat (30) begin @(negedge clk); if (done) seen++; end
    chk("abort_nodone", 32'(seen), 32'd0);
    rd(2'd2, 32'h0, "abort_nowb");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
